// File: rtl/tempo_pkg.sv
// Shared types and tempo helpers for the step sequencer.
package tempo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int unsigned NUM_PRESETS = 8;

   // Tempo presets in BPM, ascending, so entry 0 has the longest period.
   localparam int unsigned BPM_TABLE [NUM_PRESETS] = '{40, 60, 80, 100, 120, 140, 180, 220};

   // Cycles per beat, floor((clk_hz*60)/bpm); 64-bit math avoids overflow at high clock rates.
   function automatic int unsigned period(input int unsigned clk_hz, input int unsigned bpm);
      longint unsigned p;
      p = (64'(clk_hz) * 64'd60) / 64'(bpm);
      return 32'(p);
   endfunction

   // Bits needed to hold values 0..v-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned v);
      return (v > 32'd1) ? 32'($clog2(v)) : 32'd1;
   endfunction

endpackage

// File: rtl/tempo_divider.sv
// Reloading down-counter that produces one tick per tempo period.
module tempo_divider
   import tempo_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50000000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [2:0] speed,
   input  logic       run,
   input  logic       clear,
   output logic       tick
);

   localparam int unsigned CNT_W = cnt_width(period(CLK_HZ, BPM_TABLE[0]));

   logic [CNT_W-1:0] reload_tbl [NUM_PRESETS];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Elaboration-time reload values, one per preset.
   for (genvar g = 0; g < NUM_PRESETS; g++) begin : g_reload
      assign reload_tbl[g] = CNT_W'(period(CLK_HZ, BPM_TABLE[g]) - 32'd1);
   end

   assign tick = run && (count_q == '0);

   // Count down while running; speed is only sampled at the reload.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (run) begin
         count_d = (count_q == '0) ? reload_tbl[speed] : count_q - CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!resetn) count_q <= '0;
      else         count_q <= count_d;
   end

endmodule

// File: rtl/tempo_step_sequencer.sv
// Beat generator and step-address sequencer with start/pause/stop, looping and metronome LED.
module tempo_step_sequencer
   import tempo_pkg::*;
#(
   parameter  int unsigned CLK_HZ        = 50000000,
   parameter  int unsigned ADDR_W        = 6,
   parameter  int unsigned BEATS_PER_BAR = 4,
   parameter  int unsigned LED_HOLD      = 10000,
   localparam int unsigned BEAT_W        = cnt_width(BEATS_PER_BAR)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              pause,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [2:0]        speed,
   input  logic [ADDR_W-1:0] last_addr,
   output logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic [BEAT_W-1:0] beat_idx,
   output logic              bar_start,
   output logic              beat_led,
   output logic              busy,
   output logic              done
);

   localparam int unsigned HOLD_W = cnt_width(LED_HOLD);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              led_q, led_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   logic tick;
   logic run_c;
   logic clear_c;
   logic load_c;
   logic at_end_c;

   assign at_end_c = (addr_q >= last_addr);

   tempo_divider #(
      .CLK_HZ (CLK_HZ)
   ) u_divider (
      .clk    (clk),
      .resetn (resetn),
      .speed  (speed),
      .run    (run_c),
      .clear  (clear_c),
      .tick   (tick)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state: stop wins, start overrides pause, the final non-looping step ends the run.
   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN: begin
               if (tick && at_end_c && !loop_en) state_d = DONE;
               else if (pause && !start)         state_d = PAUSE;
            end
            PAUSE:      if (start) state_d = RUN;
            default:    state_d = IDLE;
         endcase
      end
   end

   // FSM outputs; the divider is held at zero outside RUN/PAUSE so a fresh start steps at once.
   always_comb begin
      run_c     = (state_q == RUN);
      busy      = (state_q == RUN) || (state_q == PAUSE);
      done      = (state_q == DONE);
      clear_c   = stop || (state_q == IDLE) || (state_q == DONE);
      load_c    = !stop && start && ((state_q == IDLE) || (state_q == DONE));
      step      = tick;
      bar_start = tick && (beat_q == '0);
   end

   // Address and bar position advance on each step; beat position ignores the address wrap.
   always_comb begin
      addr_d = addr_q;
      beat_d = beat_q;
      if (stop || load_c) begin
         addr_d = '0;
         beat_d = '0;
      end else if (tick) begin
         if (!at_end_c)    addr_d = addr_q + ADDR_W'(1);
         else if (loop_en) addr_d = '0;
         beat_d = (beat_q == BEAT_W'(BEATS_PER_BAR - 1)) ? '0 : beat_q + BEAT_W'(1);
      end
   end

   // LED hold: restarted by every step, keeps counting through PAUSE, cleared by stop.
   always_comb begin
      led_d  = led_q;
      hold_d = hold_q;
      if (stop) begin
         led_d  = 1'b0;
         hold_d = '0;
      end else if (tick) begin
         led_d  = 1'b1;
         hold_d = HOLD_W'(LED_HOLD - 1);
      end else if (led_q) begin
         if (hold_q == '0) led_d  = 1'b0;
         else              hold_d = hold_q - HOLD_W'(1);
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         addr_q <= '0;
         beat_q <= '0;
         led_q  <= 1'b0;
         hold_q <= '0;
      end else begin
         addr_q <= addr_d;
         beat_q <= beat_d;
         led_q  <= led_d;
         hold_q <= hold_d;
      end
   end

   assign addr     = addr_q;
   assign beat_idx = beat_q;
   assign beat_led = led_q;

endmodule

// File: tb/tb_tempo_step_sequencer.sv
// Scoreboard bench for tempo_step_sequencer: expected steps queued at stimulus time, popped on each step.
module tb_tempo_step_sequencer;

   localparam int unsigned CLK_HZ   = 400;
   localparam int unsigned ADDR_W   = 3;
   localparam int unsigned BPB      = 4;
   localparam int unsigned LED_HOLD = 5;
   localparam int unsigned BEAT_W   = 2;

   logic              clk = 1'b0;
   logic              resetn, start, pause, stop, loop_en;
   logic [2:0]        speed;
   logic [ADDR_W-1:0] last_addr;
   logic              step, bar_start, beat_led, busy, done;
   logic [ADDR_W-1:0] addr;
   logic [BEAT_W-1:0] beat_idx;

   typedef struct {
      int cyc;
      int addr;
      int beat;
   } exp_step_t;

   exp_step_t exp_q [$];
   int        cyc      = 0;
   int        n_checks = 0;
   int        n_pass   = 0;
   int        led_rem  = 0;
   bit        mon_en   = 1'b0;

   tempo_step_sequencer #(
      .CLK_HZ        (CLK_HZ),
      .ADDR_W        (ADDR_W),
      .BEATS_PER_BAR (BPB),
      .LED_HOLD      (LED_HOLD)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .pause     (pause),
      .stop      (stop),
      .loop_en   (loop_en),
      .speed     (speed),
      .last_addr (last_addr),
      .step      (step),
      .addr      (addr),
      .beat_idx  (beat_idx),
      .bar_start (bar_start),
      .beat_led  (beat_led),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) cycles(1);
   endtask

   task automatic pulse(input logic s, input logic p, input logic t, output int c);
      c     = cyc;
      start = s;
      pause = p;
      stop  = t;
      cycles(1);
      start = 1'b0;
      pause = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic expect_step(input int c, input int a, input int b);
      exp_step_t e;
      e.cyc  = c;
      e.addr = a;
      e.beat = b;
      exp_q.push_back(e);
   endtask

   task automatic check_drained(input string tag);
      check(tag, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic check_all_zero();
      check("zero_step",      32'(step),      32'd0);
      check("zero_addr",      32'(addr),      32'd0);
      check("zero_beat_idx",  32'(beat_idx),  32'd0);
      check("zero_bar_start", 32'(bar_start), 32'd0);
      check("zero_beat_led",  32'(beat_led),  32'd0);
      check("zero_busy",      32'(busy),      32'd0);
      check("zero_done",      32'(done),      32'd0);
   endtask

   // Step scoreboard and LED hold model, sampled mid-cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (step === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_step", 32'(step), 32'd0);
            end else begin
               exp_step_t e;
               e = exp_q.pop_front();
               check("step_cycle", 32'(cyc),       32'(e.cyc));
               check("step_addr",  32'(addr),      32'(e.addr));
               check("step_beat",  32'(beat_idx),  32'(e.beat));
               check("bar_start",  32'(bar_start), 32'(e.beat == 0));
            end
         end
         check("beat_led", 32'(beat_led), 32'(led_rem > 0));
         if (!resetn || stop)  led_rem = 0;
         else if (step)        led_rem = int'(LED_HOLD);
         else if (led_rem > 0) led_rem--;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int c, p, r, s, x;
      resetn    = 1'b0;
      start     = 1'b0;
      pause     = 1'b0;
      stop      = 1'b0;
      loop_en   = 1'b0;
      speed     = 3'd0;
      last_addr = '0;

      // Reset and idle
      cycles(3);
      check_all_zero();
      mon_en = 1'b1;
      resetn = 1'b1;
      cycles(2);
      check_all_zero();

      // Slowest tempo, first step immediately, then every 600 cycles
      speed     = 3'd0;
      loop_en   = 1'b1;
      last_addr = 3'd7;
      pulse(1, 0, 0, c);
      expect_step(c + 1,    0, 0);
      expect_step(c + 601,  1, 1);
      expect_step(c + 1201, 2, 2);
      wait_until(c + 2);
      check("t1_busy", 32'(busy), 32'd1);
      wait_until(c + 1210);
      pulse(0, 0, 1, s);
      check("t1_stop_addr", 32'(addr), 32'd0);
      check("t1_stop_busy", 32'(busy), 32'd0);
      check_drained("t1_pending_steps");

      // Finite sequence of three steps, then DONE holding the last address
      speed     = 3'd4;
      loop_en   = 1'b0;
      last_addr = 3'd2;
      pulse(1, 0, 0, c);
      expect_step(c + 1,   0, 0);
      expect_step(c + 201, 1, 1);
      expect_step(c + 401, 2, 2);
      wait_until(c + 401);
      check("t2_done_early", 32'(done), 32'd0);
      wait_until(c + 402);
      check("t2_done",      32'(done), 32'd1);
      check("t2_busy",      32'(busy), 32'd0);
      check("t2_done_addr", 32'(addr), 32'd2);
      wait_until(c + 700);
      check("t2_hold_addr", 32'(addr), 32'd2);
      check_drained("t2_pending_steps");

      // Degenerate single-step sequence, started from DONE
      last_addr = 3'd0;
      pulse(1, 0, 0, c);
      expect_step(c + 1, 0, 0);
      wait_until(c + 2);
      check("t2b_done", 32'(done), 32'd1);
      check("t2b_addr", 32'(addr), 32'd0);
      wait_until(c + 300);
      check_drained("t2b_pending_steps");

      // Looping sequence with bar tracking
      loop_en   = 1'b1;
      last_addr = 3'd2;
      pulse(1, 0, 0, c);
      for (int k = 0; k < 5; k++) expect_step(c + 1 + 200 * k, k % 3, k % 4);

      // Pause 50 cycles after the fifth step, resume 1000 cycles later
      wait_until(c + 851);
      pulse(0, 1, 0, p);
      wait_until(p + 500);
      check("t3_pause_busy", 32'(busy),     32'd1);
      check("t3_pause_addr", 32'(addr),     32'd2);
      check("t3_pause_beat", 32'(beat_idx), 32'd1);
      wait_until(p + 1000);
      pulse(1, 0, 0, r);
      expect_step(r + 150, 2, 1);

      // start together with pause in RUN keeps running
      wait_until(r + 160);
      pulse(1, 1, 0, x);
      expect_step(r + 350, 0, 2);

      // start together with stop in RUN goes to IDLE without a step
      wait_until(r + 400);
      pulse(1, 0, 1, s);
      check("t4_stop_busy", 32'(busy),     32'd0);
      check("t4_stop_done", 32'(done),     32'd0);
      check("t4_stop_addr", 32'(addr),     32'd0);
      check("t4_stop_beat", 32'(beat_idx), 32'd0);
      wait_until(s + 700);
      check_drained("t3_pending_steps");

      // Tempo change mid-period applies at the next reload
      speed     = 3'd0;
      loop_en   = 1'b1;
      last_addr = 3'd7;
      pulse(1, 0, 0, c);
      expect_step(c + 1,   0, 0);
      expect_step(c + 601, 1, 1);
      expect_step(c + 710, 2, 2);
      wait_until(c + 300);
      speed = 3'd7;

      // Synchronous reset mid-RUN while the LED is lit
      wait_until(c + 713);
      resetn = 1'b0;
      cycles(1);
      check_all_zero();
      resetn = 1'b1;
      cycles(20);
      check_drained("t5_pending_steps");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
